// File: rtl/vram_rect_filler_if.sv
// rtl/vram_rect_filler_if.sv - command and memory-write signals of the rectangle filler
interface vram_rect_filler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [9:0]  cmd_x0;
  logic [9:0]  cmd_x1;
  logic [8:0]  cmd_y0;
  logic [8:0]  cmd_y1;
  logic [11:0] cmd_color;
  logic        stall;
  logic        we;
  logic [18:0] waddr;
  logic [11:0] wdata;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_clear, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, stall,
    input  cmd_ready, we, waddr, wdata, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_clear, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, stall,
    output cmd_ready, we, waddr, wdata, busy, done
  );
endinterface

// File: rtl/vram_rect_filler.sv
// rtl/vram_rect_filler.sv - fills clipped rectangles or the whole frame memory in raster order
module vram_rect_filler #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input logic          clk,
  input logic          rst,
  vram_rect_filler_if.slave bus
);
  localparam logic [9:0] X_MAX = 10'(H_RES - 1);
  localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  state_t      r_state;
  logic        r_clear;
  logic [9:0]  r_x0, r_x1, r_xl, r_xh, r_x;
  logic [8:0]  r_y0, r_y1, r_yh, r_y;
  logic [11:0] r_color;
  logic        r_fin;
  logic        r_we;
  logic [18:0] r_waddr;
  logic [11:0] r_wdata;

  logic [9:0]  w_xl, w_xh;
  logic [8:0]  w_yl, w_yh;
  logic        w_empty;

  assign w_xl    = (r_x0 < r_x1) ? r_x0 : r_x1;
  assign w_xh    = (r_x0 < r_x1) ? r_x1 : r_x0;
  assign w_yl    = (r_y0 < r_y1) ? r_y0 : r_y1;
  assign w_yh    = (r_y0 < r_y1) ? r_y1 : r_y0;
  assign w_empty = (w_xl > X_MAX) || (w_yl > Y_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_clear <= 1'b0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_color <= '0;
      r_xl    <= '0;
      r_xh    <= '0;
      r_yh    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fin   <= 1'b0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_we <= 1'b0;
          if (bus.cmd_valid) begin
            r_clear <= bus.cmd_clear;
            r_x0    <= bus.cmd_x0;
            r_x1    <= bus.cmd_x1;
            r_y0    <= bus.cmd_y0;
            r_y1    <= bus.cmd_y1;
            r_color <= bus.cmd_color;
            r_state <= CLIP;
          end
        end
        CLIP: begin
          if (r_clear) begin
            r_xl  <= '0;
            r_xh  <= X_MAX;
            r_yh  <= Y_MAX;
            r_x   <= '0;
            r_y   <= '0;
            r_fin <= 1'b0;
          end else begin
            r_xl  <= w_xl;
            r_xh  <= (w_xh > X_MAX) ? X_MAX : w_xh;
            r_yh  <= (w_yh > Y_MAX) ? Y_MAX : w_yh;
            r_x   <= w_xl;
            r_y   <= w_yl;
            r_fin <= w_empty;
          end
          r_state <= FILL;
        end
        FILL: begin
          // r_fin gives the last write one cycle to land before done is raised
          if (r_fin) begin
            r_we    <= 1'b0;
            r_state <= DONE;
          end else if (bus.stall) begin
            r_we <= 1'b0;
          end else begin
            r_we    <= 1'b1;
            r_waddr <= {r_x, r_y};
            r_wdata <= r_color;
            if (r_x == r_xh) begin
              if (r_y == r_yh) begin
                r_fin <= 1'b1;
              end else begin
                r_x <= r_xl;
                r_y <= r_y + 9'd1;
              end
            end else begin
              r_x <= r_x + 10'd1;
            end
          end
        end
        DONE: begin
          r_we    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.we        = r_we;
  assign bus.waddr     = r_waddr;
  assign bus.wdata     = r_wdata;
endmodule

// File: doc/vram_rect_filler.md
Name: vram_rect_filler

Overview:
- Writer side of the video frame memory: fills axis-aligned rectangles, or clears the full screen, with a 12-bit RGB colour (4:4:4).
- Writes go through the memory's second (write) port. The VGA pixel path reads the same memory through its read port at address {h_addr[9:0], v_addr[8:0]}.
- Accepts one command at a time over a valid/ready handshake and emits one pixel write per clock in raster order.

Parameters:
- H_RES, 640, visible pixels per line; x coordinates are valid in 0..H_RES-1.
- V_RES, 480, visible lines; y coordinates are valid in 0..V_RES-1.

Ports:
- clk  input  1  system clock (pixel clock domain of the memory write port)
- rst  input  1  reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_clear  input  1  1 = fill the whole screen; coordinates are ignored
- cmd_x0, cmd_x1  input  10  rectangle x corners, any order
- cmd_y0, cmd_y1  input  9  rectangle y corners, any order
- cmd_color  input  12  fill colour {R[3:0], G[3:0], B[3:0]}
- stall  input  1  memory port busy; hold the fill
- we  output  1  memory write enable
- waddr  output  19  memory address {x[9:0], y[8:0]}
- wdata  output  12  write data
- busy  output  1  command in progress
- done  output  1  one-cycle completion pulse

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset: when rst is sampled high at a clk edge, the block goes to state IDLE and all command registers clear. At that edge: we=0, waddr=0, wdata=0, busy=0, done=0, cmd_ready=1. Reset overrides everything, including a fill in progress; no further writes occur after the reset edge.
- States: IDLE, CLIP, FILL, DONE. All outputs are registered or decoded from state.
- Status decoding: cmd_ready=1 only in IDLE. busy=1 in CLIP, FILL and DONE. done=1 only in DONE.
- IDLE: if cmd_valid and cmd_ready are both 1 at an edge (cycle N), latch the command and go to CLIP. A cmd_valid arriving while not in IDLE is ignored; it is not queued.
- CLIP (cycle N+1):
  - Order the corners: xl=min(x0,x1), xh=max(x0,x1); yl and yh likewise.
  - Clamp xh to H_RES-1 and yh to V_RES-1.
  - If xl>=H_RES or yl>=V_RES, the rectangle is empty: go to DONE with no writes.
  - If cmd_clear=1: xl=0, xh=H_RES-1, yl=0, yh=V_RES-1.
  - Otherwise load x=xl, y=yl and go to FILL.
- FILL:
  - Each cycle with stall=0: we=1, waddr={x,y}, wdata=color (all registered).
  - Then advance: x++; when x==xh, set x=xl and y++. After writing (xh,yh), go to DONE.
  - While stall=1: we=0, the counters hold, and waddr/wdata hold their last value.
  - Unstalled, the first write is at cycle N+2. A rectangle of P pixels completes its writes at N+1+P.
- DONE: done=1, we=0 for exactly one cycle, then IDLE. The next command can be accepted in the cycle after DONE.
- Latency without stall: done at N+2+P. An empty rectangle gives done at N+2.
- Width rules: x compare and increment use 10 bits, y uses 9 bits. There is no wrap beyond xh/yh. The maximum P is H_RES*V_RES = 307200.
- cmd_color and cmd_clear are sampled only at acceptance. Input changes after acceptance have no effect.
- stall is sampled only in FILL; in the other states it has no effect.

Test Plan:
- Single pixel: accept x0=x1=10, y0=y1=20, color 0xF00 at N -> exactly one write at N+2, waddr=5140, wdata=0xF00; done=1 at N+3 only; cmd_ready=1 at N+4.
- Swapped corners: x0=5, x1=4, y0=3, y1=2, color 0x0F0 -> 4 writes in order (4,2),(5,2),(4,3),(5,3), i.e. waddr 2050, 2562, 2051, 2563; done at N+6.
- Clipping: x0=630, x1=700, y0=479, y1=500 -> 10 writes (630..639, 479), last waddr=327647. Off-screen x0=x1=640 -> zero writes, done at N+2.
- Stall: 2x2 fill with stall=1 for 3 cycles after the first write -> we=0 during the stall, no pixel skipped or duplicated, done delayed by exactly 3 cycles (N+9).
- Reset mid-fill: rst high during the 5th write of a 10x10 fill -> at that edge we=0, busy=0, cmd_ready=1, no done pulse; a new command then runs normally.
- Clear: cmd_clear=1, color 0x00F -> 307200 writes, first waddr=0, last waddr=327647 (639,479); done at N+307202; cmd_valid held high while busy is not accepted.
